// File: rtl/ap3_io_pkg.sv
// Shared definitions for AP3 pad-cell fabric logic: legal parameter ranges,
// the filter state encoding and the counter-width helper.
package ap3_io_pkg;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int FILTER_CYCLES_MAX = 255;

  typedef enum logic {
    FILT_IDLE    = 1'b0,
    FILT_PENDING = 1'b1
  } filt_state_e;

  // A one-cycle filter still needs a 1-bit counter so the vector is never empty.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/io_sync_chain.sv
// Multi-flop synchronizer for an asynchronous pad level. Stage 1 is the
// metastability capture flop; the last stage is the only safe output.
module io_sync_chain
  import ap3_io_pkg::*;
#(
  parameter int   DEPTH      = 2,
  parameter logic INIT_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (DEPTH < SYNC_STAGES_MIN) begin : g_bad_depth
    $error("io_sync_chain: DEPTH %0d below minimum %0d", DEPTH, SYNC_STAGES_MIN);
  end

  (* async_reg = "true" *) logic [DEPTH-1:0] stages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= {DEPTH{INIT_VALUE}};
    end else begin
      stages <= {stages[DEPTH-2:0], d};
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/input_io_capture.sv
// AP3 input pad receive path: synchronize A2F, accept only levels that persist
// for FILTER_CYCLES enabled cycles, and flag accepted edges with IQR/IQF.
module input_io_capture
  import ap3_io_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic INIT_VALUE    = 1'b0
) (
  input  logic IQC,
  input  logic QRT,
  input  logic A2F,
  input  logic IQE,
  output logic IQZ,
  output logic IQR,
  output logic IQF
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("input_io_capture: SYNC_STAGES %0d out of range", SYNC_STAGES);
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > FILTER_CYCLES_MAX) begin : g_bad_filter
    $error("input_io_capture: FILTER_CYCLES %0d out of range", FILTER_CYCLES);
  end

  localparam int            CW       = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          s;
  logic [CW-1:0] count;
  filt_state_e   filter_state;
  logic          at_last;

  io_sync_chain #(
    .DEPTH      (SYNC_STAGES),
    .INIT_VALUE (INIT_VALUE)
  ) u_sync (
    .clk (IQC),
    .rst (QRT),
    .d   (A2F),
    .q   (s)
  );

  // The filter state is not stored: it is fully implied by s versus IQZ.
  always_comb begin
    filter_state = (s != IQZ) ? FILT_PENDING : FILT_IDLE;
    at_last      = (count == CNT_LAST);
  end

  always_ff @(posedge IQC or posedge QRT) begin
    if (QRT) begin
      count <= '0;
      IQZ   <= INIT_VALUE;
      IQR   <= 1'b0;
      IQF   <= 1'b0;
    end else begin
      IQR <= 1'b0;
      IQF <= 1'b0;
      if (IQE) begin
        if (filter_state == FILT_IDLE) begin
          count <= '0;
        end else if (at_last) begin
          IQZ   <= s;
          count <= '0;
          IQR   <= s;
          IQF   <= ~s;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule
